// File: rtl/tile_mac_accumulator.sv
// tile_mac_accumulator: one grid position of the Cannon matrix-multiply datapath.
// Accepts SQRT_P pairs of m x m tiles and accumulates C += A*B with a single
// multiply-accumulate per cycle, then presents C until the consumer takes it.
module tile_mac_accumulator #(
  parameter int N_DIVIDE_PS = 2,
  parameter int SQRT_P      = 2,
  parameter int WIDTH       = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [WIDTH*N_DIVIDE_PS*N_DIVIDE_PS-1:0]   tile_a,
  input  logic [WIDTH*N_DIVIDE_PS*N_DIVIDE_PS-1:0]   tile_b,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [WIDTH*N_DIVIDE_PS*N_DIVIDE_PS-1:0]   acc_out,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       busy
);

  localparam int M  = N_DIVIDE_PS;
  localparam int MM = M * M;
  localparam int TW = WIDTH * MM;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int RW = (SQRT_P > 1) ? $clog2(SQRT_P) : 1;
  localparam logic [CW-1:0] IDX_LAST   = CW'(M - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(SQRT_P - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

  state_t state, next_state;

  logic [TW-1:0]    a_reg, b_reg, acc;
  logic [CW-1:0]    row, col, kk;
  logic [RW-1:0]    round;
  logic             last_mac;
  logic [WIDTH-1:0] a_elem, b_elem, acc_elem, product;

  assign last_mac = (row == IDX_LAST) && (col == IDX_LAST) && (kk == IDX_LAST);
  assign acc_out  = acc;

  // The low WIDTH bits of a two's complement product equal those of the
  // unsigned product, so a WIDTH-wide multiply gives the wrapped result directly.
  assign product = a_elem * b_elem;

  // Select a[row][kk], b[kk][col] and acc[row][col] for the current MAC step.
  always_comb begin
    a_elem   = '0;
    b_elem   = '0;
    acc_elem = '0;
    for (int e = 0; e < MM; e++) begin
      if (e == int'(row) * M + int'(kk))  a_elem   = a_reg[e*WIDTH +: WIDTH];
      if (e == int'(kk) * M + int'(col))  b_elem   = b_reg[e*WIDTH +: WIDTH];
      if (e == int'(row) * M + int'(col)) acc_elem = acc[e*WIDTH +: WIDTH];
    end
  end

  // State register; reset abandons any product in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) next_state = COMPUTE;
      end
      COMPUTE: begin
        if (last_mac) next_state = (round == ROUND_LAST) ? DONE : LOAD;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: tile capture, MAC index walk (k fastest, then c, then r) and accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      row   <= '0;
      col   <= '0;
      kk    <= '0;
      round <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            round <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            a_reg <= tile_a;
            b_reg <= tile_b;
            row   <= '0;
            col   <= '0;
            kk    <= '0;
          end
        end
        COMPUTE: begin
          for (int e = 0; e < MM; e++) begin
            if (e == int'(row) * M + int'(col)) acc[e*WIDTH +: WIDTH] <= acc_elem + product;
          end
          kk <= (kk == IDX_LAST) ? '0 : kk + CW'(1);
          if (kk == IDX_LAST) begin
            col <= (col == IDX_LAST) ? '0 : col + CW'(1);
            if (col == IDX_LAST) row <= (row == IDX_LAST) ? '0 : row + CW'(1);
          end
          if (last_mac && (round != ROUND_LAST)) round <= round + RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_mac_accumulator.sv
// tb_tile_mac_accumulator: self-checking bench with two instances, one
// accumulating a single round and one accumulating two rounds.
module tb_tile_mac_accumulator;

  localparam int W          = 32;
  localparam int M          = 2;
  localparam int TW         = W * M * M;
  localparam int MAC_CYCLES = M * M * M;

  typedef logic [TW-1:0] tile_t;

  typedef struct {
    tile_t a0, b0, a1, b1;
    int    stall;
    bit    ghost;
    bit    start_on_release;
    int    hold;
    tile_t exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  tile_t tile_a, tile_b;
  logic  start_v [2];
  logic  in_valid_v [2];
  logic  out_ready_v [2];
  logic  in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  tile_t acc0, acc1;

  int    checks = 0;
  int    errors = 0;
  tile_t sb_q [$];
  vec_t  vecs [4];

  tile_mac_accumulator #(.N_DIVIDE_PS(M), .SQRT_P(1), .WIDTH(W)) dut_single (
    .clk(clk), .rst(rst), .start(start_v[0]), .tile_a(tile_a), .tile_b(tile_b),
    .in_valid(in_valid_v[0]), .in_ready(in_ready0), .acc_out(acc0),
    .out_valid(out_valid0), .out_ready(out_ready_v[0]), .busy(busy0)
  );

  tile_mac_accumulator #(.N_DIVIDE_PS(M), .SQRT_P(2), .WIDTH(W)) dut_double (
    .clk(clk), .rst(rst), .start(start_v[1]), .tile_a(tile_a), .tile_b(tile_b),
    .in_valid(in_valid_v[1]), .in_ready(in_ready1), .acc_out(acc1),
    .out_valid(out_valid1), .out_ready(out_ready_v[1]), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Hard time limit so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic in_ready_of(input int sel);
    return (sel == 1) ? in_ready1 : in_ready0;
  endfunction

  function automatic logic out_valid_of(input int sel);
    return (sel == 1) ? out_valid1 : out_valid0;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? busy1 : busy0;
  endfunction

  function automatic tile_t acc_of(input int sel);
    return (sel == 1) ? acc1 : acc0;
  endfunction

  function automatic tile_t pack2(input logic [31:0] e00, input logic [31:0] e01,
                                  input logic [31:0] e10, input logic [31:0] e11);
    return {e11, e10, e01, e00};
  endfunction

  // Reference: acc + a*b over m x m tiles, each sum wrapping modulo 2^W.
  function automatic tile_t mac_model(input tile_t acc, input tile_t a, input tile_t b);
    tile_t       res;
    logic [31:0] s;
    res = acc;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < M; c++) begin
        s = res[(r*M+c)*W +: W];
        for (int k = 0; k < M; k++) s = s + a[(r*M+k)*W +: W] * b[(k*M+c)*W +: W];
        res[(r*M+c)*W +: W] = s;
      end
    end
    return res;
  endfunction

  function automatic tile_t rand_tile();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input tile_t actual, input tile_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic startProduct(input int sel);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    checkOutput("in_ready after start", tile_t'(in_ready_of(sel)), tile_t'(1));
  endtask

  // Offer one tile pair, then walk the m^3 COMPUTE cycles checking exact latency.
  task automatic applyStimulus(input int sel, input tile_t a, input tile_t b,
                               input int stall, input bit ghost, input bit final_round);
    int    n;
    tile_t acc_before;
    n = 0;
    while (!in_ready_of(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_of(sel)) checkOutput("load wait timeout", tile_t'(in_ready_of(sel)), tile_t'(1));
    acc_before = acc_of(sel);
    repeat (stall) @(negedge clk);
    if (stall > 0) begin
      checkOutput("in_ready held in LOAD stall", tile_t'(in_ready_of(sel)), tile_t'(1));
      checkOutput("acc stable in LOAD stall", acc_of(sel), acc_before);
    end
    tile_a = a;
    tile_b = b;
    in_valid_v[sel] = 1'b1;
    @(negedge clk);
    in_valid_v[sel] = 1'b0;
    tile_a = rand_tile();
    tile_b = rand_tile();
    checkOutput("in_ready low in COMPUTE", tile_t'(in_ready_of(sel)), tile_t'(0));
    checkOutput("busy in COMPUTE", tile_t'(busy_of(sel)), tile_t'(1));
    for (int i = 2; i <= MAC_CYCLES; i++) begin
      if (ghost && i == 3) begin
        in_valid_v[sel] = 1'b1;
        tile_a = pack2(100, 200, 300, 400);
        tile_b = pack2(9, 9, 9, 9);
      end
      @(negedge clk);
      in_valid_v[sel] = 1'b0;
    end
    checkOutput("still computing at t+m^3", tile_t'({in_ready_of(sel), out_valid_of(sel)}), tile_t'(0));
    @(negedge clk);
    if (final_round)
      checkOutput("out_valid at t+m^3+1", tile_t'(out_valid_of(sel)), tile_t'(1));
    else
      checkOutput("in_ready at t+m^3+1", tile_t'(in_ready_of(sel)), tile_t'(1));
  endtask

  // Wait (bounded) for out_valid and compare against the scoreboard head.
  task automatic waitOutput(input int sel, input string name);
    int    n;
    tile_t exp;
    n = 0;
    while (!out_valid_of(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_of(sel)) checkOutput("out_valid timeout", tile_t'(out_valid_of(sel)), tile_t'(1));
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard empty", acc_of(sel), '0);
    end else begin
      exp = sb_q.pop_front();
      checkOutput(name, acc_of(sel), exp);
    end
  endtask

  task automatic releaseOutput(input int sel, input int hold, input bit with_start);
    tile_t held;
    held = acc_of(sel);
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      checkOutput("out_valid held in DONE stall", tile_t'(out_valid_of(sel)), tile_t'(1));
      checkOutput("acc stable in DONE stall", acc_of(sel), held);
    end
    out_ready_v[sel] = 1'b1;
    start_v[sel] = with_start;
    @(negedge clk);
    out_ready_v[sel] = 1'b0;
    start_v[sel] = 1'b0;
    checkOutput("out_valid cleared after accept", tile_t'(out_valid_of(sel)), tile_t'(0));
    checkOutput("idle after accept", tile_t'(busy_of(sel)), tile_t'(0));
    checkOutput("acc kept after accept", acc_of(sel), held);
    if (with_start) begin
      @(negedge clk);
      checkOutput("start in DONE ignored", tile_t'(busy_of(sel)), tile_t'(0));
    end
  endtask

  initial begin
    tile_t pa, pb, ia, ones, sa, sb;
    pa   = pack2(1, 2, 3, 4);
    pb   = pack2(5, 6, 7, 8);
    ia   = pack2(1, 0, 0, 1);
    ones = pack2(1, 1, 1, 1);
    sa   = pack2(-1, 0, 0, 1);
    sb   = pack2(3, 0, 0, 32'h7FFF_FFFF);

    vecs[0] = '{a0: pa, b0: pb, a1: ia, b1: ones, stall: 5, ghost: 1'b0,
                start_on_release: 1'b0, hold: 4, exp: pack2(20, 23, 44, 51)};
    vecs[1] = '{a0: sa, b0: sb, a1: sa, b1: sb, stall: 0, ghost: 1'b1,
                start_on_release: 1'b1, hold: 0, exp: pack2(-6, 0, 0, 32'hFFFF_FFFE)};
    for (int i = 2; i < 4; i++) begin
      vecs[i].a0 = rand_tile();
      vecs[i].b0 = rand_tile();
      vecs[i].a1 = rand_tile();
      vecs[i].b1 = rand_tile();
      vecs[i].stall = int'($urandom_range(0, 3));
      vecs[i].ghost = 1'b0;
      vecs[i].start_on_release = 1'b0;
      vecs[i].hold = 1;
      vecs[i].exp = mac_model(mac_model('0, vecs[i].a0, vecs[i].b0), vecs[i].a1, vecs[i].b1);
    end

    rst = 1'b1;
    tile_a = '0;
    tile_b = '0;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      in_valid_v[s] = 1'b0;
      out_ready_v[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Enter LOAD, then hit reset between clock edges.
    startProduct(0);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset in_ready", tile_t'(in_ready0), tile_t'(0));
    checkOutput("reset out_valid", tile_t'(out_valid0), tile_t'(0));
    checkOutput("reset busy", tile_t'(busy0), tile_t'(0));
    checkOutput("reset acc_out", acc0, '0);
    checkOutput("reset double instance", {acc1[TW-1:3], in_ready1, out_valid1, busy1}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Single round on the SQRT_P=1 instance, with a DONE stall.
    startProduct(0);
    sb_q.push_back(mac_model('0, pa, pb));
    applyStimulus(0, pa, pb, 0, 1'b0, 1'b1);
    waitOutput(0, "single round result");
    releaseOutput(0, 4, 1'b0);

    // Two-round accumulation vectors on the SQRT_P=2 instance.
    for (int i = 0; i < 4; i++) begin
      startProduct(1);
      applyStimulus(1, vecs[i].a0, vecs[i].b0, vecs[i].stall, vecs[i].ghost, 1'b0);
      sb_q.push_back(vecs[i].exp);
      applyStimulus(1, vecs[i].a1, vecs[i].b1, 0, 1'b0, 1'b1);
      waitOutput(1, $sformatf("vector %0d result", i));
      releaseOutput(1, vecs[i].hold, vecs[i].start_on_release);
    end

    // Reset during the 4th MAC cycle of round 1 must discard everything.
    startProduct(1);
    applyStimulus(1, pa, pb, 0, 1'b0, 1'b0);
    tile_a = ia;
    tile_b = ones;
    in_valid_v[1] = 1'b1;
    @(negedge clk);
    in_valid_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid-compute reset busy", tile_t'(busy1), tile_t'(0));
    checkOutput("mid-compute reset in_ready", tile_t'(in_ready1), tile_t'(0));
    checkOutput("mid-compute reset acc_out", acc1, '0);
    @(negedge clk);
    rst = 1'b0;

    startProduct(1);
    applyStimulus(1, pa, pb, 0, 1'b0, 1'b0);
    sb_q.push_back(pack2(19, 22, 43, 50));
    applyStimulus(1, '0, rand_tile(), 0, 1'b0, 1'b1);
    waitOutput(1, "post-reset result");
    releaseOutput(1, 0, 1'b0);

    startProduct(0);
    sb_q.push_back(pack2(19, 22, 43, 50));
    applyStimulus(0, pa, pb, 0, 1'b0, 1'b1);
    waitOutput(0, "single round after reset");
    releaseOutput(0, 0, 1'b0);

    checkOutput("scoreboard drained", tile_t'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
